// File: rtl/uart_frame_parser_if.sv
// Byte-stream input, payload read port and frame status bundle for uart_frame_parser.
interface uart_frame_parser_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_valid;
  logic [7:0]        frame_cmd;
  logic [7:0]        frame_len;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    output rx_data, rx_ready, rd_addr,
    input  rd_data, frame_valid, frame_cmd, frame_len, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_ready, rd_addr,
    output rd_data, frame_valid, frame_cmd, frame_len, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/LEN/payload/CHK frames from a UART byte stream, checking
// length, XOR checksum and inter-byte timeout; payload exposed via a read port.
module uart_frame_parser #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter logic [7:0]  SOF_BYTE     = 8'h7E,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * 20,
  parameter int unsigned ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_frame_parser_if.slave bus
);

  localparam int unsigned TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [7:0]       cmd_tmp;
  logic [7:0]       len_tmp;
  logic [7:0]       chk;
  logic [7:0]       cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic             wr_en;
  logic             good;
  logic             err_set;
  logic [1:0]       err_code_nxt;

  logic             frame_valid_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;
  logic [7:0]       frame_cmd_q;
  logic [7:0]       frame_len_q;
  logic [7:0]       rd_data_q;
  logic             busy_q;

  logic [7:0]       payload [MAX_LEN];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-byte control decode
  always_comb begin
    state_nxt    = state;
    wr_en        = 1'b0;
    good         = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 2'd0;
    case (state)
      S_IDLE: if (bus.rx_ready && bus.rx_data == SOF_BYTE) state_nxt = S_CMD;
      S_CMD:  if (bus.rx_ready) state_nxt = S_LEN;
      S_LEN: begin
        if (bus.rx_ready) begin
          if (bus.rx_data > MAX_LEN_B) begin
            err_set      = 1'b1;
            err_code_nxt = 2'd1;
            state_nxt    = S_IDLE;
          end else begin
            state_nxt = (bus.rx_data != 8'd0) ? S_DATA : S_CHK;
          end
        end
      end
      S_DATA: begin
        if (bus.rx_ready) begin
          wr_en = 1'b1;
          if (cnt == len_tmp - 8'd1) state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (bus.rx_ready) begin
          if (bus.rx_data == chk) begin
            good = 1'b1;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = 2'd2;
          end
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A byte on the terminal count wins; timeout only fires on a silent cycle
    if (state != S_IDLE && !bus.rx_ready && tmo_cnt == TMO_LAST) begin
      err_set      = 1'b1;
      err_code_nxt = 2'd3;
      state_nxt    = S_IDLE;
    end
  end

  // Frame assembly datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_tmp       <= 8'd0;
      len_tmp       <= 8'd0;
      chk           <= 8'd0;
      cnt           <= 8'd0;
      tmo_cnt       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      frame_cmd_q   <= 8'd0;
      frame_len_q   <= 8'd0;
      busy_q        <= 1'b0;
    end else begin
      frame_valid_q <= good;
      frame_err_q   <= err_set;
      busy_q        <= (state_nxt != S_IDLE);
      if (err_set) err_code_q <= err_code_nxt;
      if (good) begin
        frame_cmd_q <= cmd_tmp;
        frame_len_q <= len_tmp;
      end

      if (state_nxt == S_IDLE || bus.rx_ready) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (bus.rx_ready) begin
        case (state)
          S_CMD: begin
            cmd_tmp <= bus.rx_data;
            chk     <= bus.rx_data;
          end
          S_LEN: begin
            len_tmp <= bus.rx_data;
            chk     <= chk ^ bus.rx_data;
            cnt     <= 8'd0;
          end
          S_DATA: begin
            chk <= chk ^ bus.rx_data;
            cnt <= cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Payload storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) payload[cnt[ADDR_W-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= 8'd0;
    else     rd_data_q <= payload[bus.rd_addr];
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.frame_cmd   = frame_cmd_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed scoreboard bench for uart_frame_parser (MAX_LEN=16, TIMEOUT_CLKS=100).
module tb_uart_frame_parser;

  logic clk;
  logic rst;

  uart_frame_parser_if #(.ADDR_W(4)) bus ();

  uart_frame_parser #(
    .SOF_BYTE    (8'h7E),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(100),
    .ADDR_W      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] cmd;
    logic [7:0] len;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_cmd;
  logic [7:0] last_len;
  int         checks;
  int         errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ok(input logic [7:0] cmd, input logic [7:0] len);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = 2'd0;
    e.cmd    = cmd;
    e.len    = len;
    last_cmd = cmd;
    last_len = len;
    sb.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1;
    e.code   = code;
    e.cmd    = last_cmd;
    e.len    = last_len;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic release_rx();
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      send(bytes[i]);
      release_rx();
    end
  endtask

  task automatic read_check(input logic [3:0] addr, input logic [7:0] exp, input string tag);
    @(negedge clk);
    bus.rd_addr = addr;
    @(negedge clk);
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  // Pop the scoreboard on every status pulse
  always @(negedge clk) begin
    if (bus.frame_valid || bus.frame_err) begin
      exp_t e;
      check("pulse_exclusive", 32'(bus.frame_valid & bus.frame_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.frame_valid, bus.frame_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(bus.frame_err), 32'(e.is_err));
        if (e.is_err) check("err_code", 32'(bus.err_code), 32'(e.code));
        check("frame_cmd", 32'(bus.frame_cmd), 32'(e.cmd));
        check("frame_len", 32'(bus.frame_len), 32'(e.len));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.frame_valid), 32'd0);
    check({tag, "_err"},   32'(bus.frame_err),   32'd0);
    check({tag, "_code"},  32'(bus.err_code),    32'd0);
    check({tag, "_cmd"},   32'(bus.frame_cmd),   32'd0);
    check({tag, "_len"},   32'(bus.frame_len),   32'd0);
    check({tag, "_rd"},    32'(bus.rd_data),     32'd0);
    check({tag, "_busy"},  32'(bus.busy),        32'd0);
  endtask

  logic [7:0] good1[$] = '{8'h7E, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
  logic [7:0] zero2[$] = '{8'h00, 8'hFF, 8'h7E, 8'h05, 8'h00, 8'h05};
  logic [7:0] bad3[$]  = '{8'h7E, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};

  initial begin
    checks       = 0;
    errors       = 0;
    last_cmd     = 8'h00;
    last_len     = 8'h00;
    rst          = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_addr  = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Good frame with payload readback
    push_ok(8'h01, 8'h02);
    send_frame(good1);
    read_check(4'd0, 8'h11, "c1_rd0");
    read_check(4'd1, 8'h22, "c1_rd1");

    // Leading garbage then a zero-length frame
    push_ok(8'h05, 8'h00);
    send_frame(zero2);
    check("c2_busy_idle", 32'(bus.busy), 32'd0);

    // Bad checksum leaves cmd/len alone, then a good frame recovers
    push_err(2'd2);
    send_frame(bad3);
    repeat (2) @(negedge clk);
    check("c3_cmd_hold", 32'(bus.frame_cmd), 32'h05);
    check("c3_len_hold", 32'(bus.frame_len), 32'h00);
    push_ok(8'h01, 8'h02);
    send_frame(good1);

    // Overlength, followed back-to-back by a fresh frame
    push_err(2'd1);
    push_ok(8'h01, 8'h02);
    send(8'h7E); send(8'h01); send(8'h11);
    foreach (good1[i]) send(good1[i]);
    release_rx();
    read_check(4'd1, 8'h22, "c4_rd1");

    // Timeout: error exactly 100 cycles after the last strobe
    push_err(2'd3);
    send(8'h7E);
    send(8'h01);
    release_rx();
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1 || i >= 99) check("c5_timeout_pulse", 32'(bus.frame_err), 32'(i == 100));
    end
    @(negedge clk);
    check("c5_busy_after", 32'(bus.busy), 32'd0);

    // Byte on the terminal cycle beats the timeout
    push_ok(8'h01, 8'h00);
    send(8'h7E);
    send(8'h01);
    release_rx();
    repeat (98) @(negedge clk);
    check("c5b_no_err_yet", 32'(bus.frame_err), 32'd0);
    send(8'h00);
    release_rx();
    check("c5b_busy_after_len", 32'(bus.busy), 32'd1);
    send(8'h01);
    release_rx();

    // Reset during DATA abandons the frame silently
    send(8'h7E); send(8'h02); send(8'h03); send(8'hAA);
    release_rx();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("c6_rst");

    // Back-to-back strobes on six consecutive cycles
    push_ok(8'h01, 8'h02);
    foreach (good1[i]) send(good1[i]);
    release_rx();
    read_check(4'd0, 8'h11, "c6_rd0");
    read_check(4'd1, 8'h22, "c6_rd1");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
